// File: rtl/mpc_vector_ram_master_pkg.sv
// mpc_vector_ram_pkg: shared types and constants for the vector RAM port master
package mpc_vector_ram_pkg;
    localparam int CmdAddrWidth = 3;
    localparam int BufDepth = 2;
    typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;
    typedef struct packed {
        logic                  write;
        logic [CmdAddrWidth-1:0] base;
        logic [CmdAddrWidth:0]   len;
    } cmd_t;
endpackage

// File: rtl/mpc_vector_ram_master_if.sv
// mpc_vector_ram_if: command, load/dump streams and RAM port of the vector RAM master
interface mpc_vector_ram_if #(
    parameter int DataWidth = 32,
    parameter int AddressWidth = 3
);
    logic                    cmd_valid, cmd_ready, cmd_write;
    logic [AddressWidth-1:0] cmd_base;
    logic [AddressWidth:0]   cmd_len;
    logic                    wr_valid, wr_ready;
    logic [DataWidth-1:0]    wr_data;
    logic                    rd_valid, rd_ready, rd_last;
    logic [DataWidth-1:0]    rd_data;
    logic                    done;
    logic [AddressWidth-1:0] address0;
    logic                    ce0, we0;
    logic [DataWidth-1:0]    d0, q0;
    modport master (
        input  cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, q0,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, address0, ce0, we0, d0
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, q0,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, address0, ce0, we0, d0
    );
endinterface

// File: rtl/mpc_vector_ram_master_rdbuf.sv
// mpc_vector_ram_rdbuf: 2-entry FIFO holding RAM read words and their last flag
module mpc_vector_ram_rdbuf
    import mpc_vector_ram_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 push_last_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] head_data_o,
    output logic                 head_last_o,
    output logic [1:0]           occ_o
);
    logic [DataWidth:0] mem_q [BufDepth];
    logic               wr_q, rd_q;
    logic [1:0]         occ_q;

    // storage, pointers and occupancy; the caller never pushes when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BufDepth; i++) mem_q[i] <= '0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            occ_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= {push_last_i, push_data_i};
                wr_q <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign {head_last_o, head_data_o} = mem_q[rd_q];
    assign occ_o = occ_q;
endmodule

// File: rtl/mpc_vector_ram_master.sv
// mpc_vector_ram_master: streams vectors into / out of a read-first single-port RAM
module mpc_vector_ram_master
    import mpc_vector_ram_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddressWidth = CmdAddrWidth,
    parameter int AddressRange = 8
) (
    input  logic             clk,
    input  logic             reset,
    mpc_vector_ram_if.master bus
);
    localparam logic [AddressWidth:0]   RangeLen = (AddressWidth + 1)'(AddressRange);
    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);

    state_t                  state_q;
    cmd_t                    cmd;
    logic [AddressWidth-1:0] ptr_q, ptr_d;
    logic [AddressWidth:0]   issue_left_q, pop_left_q;
    logic                    inflight_q, inflight_last_q;
    logic                    wr_fire, issue, pop, head_last;
    logic [1:0]              occ;
    logic [DataWidth-1:0]    head_data;

    // clamp incoming length to the RAM size; pointer wraps at AddressRange, not 2^AddressWidth
    always_comb begin
        cmd.write = bus.cmd_write;
        cmd.base = bus.cmd_base;
        cmd.len = (bus.cmd_len > RangeLen) ? RangeLen : bus.cmd_len;
        ptr_d = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
    end

    assign wr_fire = state_q == WRITE && bus.wr_valid;
    assign pop = bus.rd_valid && bus.rd_ready;
    // a read may issue only if buffer + in-flight stays within the buffer depth after this pop
    assign issue = state_q == READ && issue_left_q != '0 &&
                   ({1'b0, occ} + {2'b0, inflight_q} < 3'(BufDepth) + {2'b0, pop});

    // command FSM with pointer and remaining-issue / remaining-pop counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            issue_left_q <= '0;
            pop_left_q <= '0;
            inflight_q <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) inflight_last_q <= issue_left_q == (AddressWidth + 1)'(1);
            if (wr_fire || issue) begin
                ptr_q <= ptr_d;
                issue_left_q <= issue_left_q - 1'b1;
            end
            if (pop) pop_left_q <= pop_left_q - 1'b1;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    ptr_q <= cmd.base;
                    issue_left_q <= cmd.len;
                    pop_left_q <= cmd.len;
                    state_q <= (cmd.len == '0) ? FIN : (cmd.write ? WRITE : READ);
                end
                WRITE: if (wr_fire && issue_left_q == (AddressWidth + 1)'(1)) state_q <= FIN;
                READ: if (pop && pop_left_q == (AddressWidth + 1)'(1)) state_q <= FIN;
                default: state_q <= IDLE;
            endcase
        end
    end

    mpc_vector_ram_rdbuf #(.DataWidth(DataWidth)) u_rdbuf (
        .clk(clk),
        .rst_n(reset),
        .push_i(inflight_q),
        .push_data_i(bus.q0),
        .push_last_i(inflight_last_q),
        .pop_i(pop),
        .head_data_o(head_data),
        .head_last_o(head_last),
        .occ_o(occ)
    );

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.wr_ready = state_q == WRITE;
    assign bus.done = state_q == FIN;
    assign bus.we0 = wr_fire;
    assign bus.ce0 = wr_fire || issue;
    assign bus.d0 = wr_fire ? bus.wr_data : '0;
    assign bus.address0 = ptr_q;
    assign bus.rd_valid = occ != 2'd0;
    assign bus.rd_data = head_data;
    assign bus.rd_last = head_last && bus.rd_valid;
endmodule

// File: tb/tb_mpc_vector_ram_master.sv
// tb_mpc_vector_ram_master: directed checks of load, dump, wrap, clamp, backpressure and reset abort
module tb_mpc_vector_ram_master;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] mem1 [8];
    logic [31:0] mem2 [8];

    always #5 clk = ~clk;

    mpc_vector_ram_if #(.DataWidth(32), .AddressWidth(3)) b1 ();
    mpc_vector_ram_if #(.DataWidth(32), .AddressWidth(3)) b2 ();

    mpc_vector_ram_master #(.DataWidth(32), .AddressWidth(3), .AddressRange(8)) u1 (
        .clk(clk), .reset(reset), .bus(b1.master));
    mpc_vector_ram_master #(.DataWidth(32), .AddressWidth(3), .AddressRange(6)) u2 (
        .clk(clk), .reset(reset), .bus(b2.master));

    always @(posedge clk) if (b1.ce0) begin
        if (b1.we0) mem1[b1.address0] <= b1.d0;
        b1.q0 <= mem1[b1.address0];
    end
    always @(posedge clk) if (b2.ce0) begin
        if (b2.we0) mem2[b2.address0] <= b2.d0;
        b2.q0 <= mem2[b2.address0];
    end

    task automatic test_reset;
        logic [9:0] obs;
        b1.cmd_valid = 0; b1.cmd_write = 0; b1.cmd_base = 0; b1.cmd_len = 0;
        b1.wr_valid = 0; b1.wr_data = 0; b1.rd_ready = 0;
        b2.cmd_valid = 0; b2.cmd_write = 0; b2.cmd_base = 0; b2.cmd_len = 0;
        b2.wr_valid = 0; b2.wr_data = 0; b2.rd_ready = 0;
        reset = 0;
        @(negedge clk); #1;
        obs = {b1.cmd_ready, b1.wr_ready, b1.rd_valid, b1.rd_last, b1.done, b1.ce0, b1.we0, b1.address0};
        tests++;
        if (obs !== 10'b1000000000) begin fails++; $display("FAIL reset_outputs: got %b expected %b", obs, 10'b1000000000); end
        tests++;
        if ({b1.rd_data, b1.d0} !== 64'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", {b1.rd_data, b1.d0}); end
        @(negedge clk); reset = 1;
    endtask

    task automatic test_load;
        logic [37:0] obs, exp;
        @(negedge clk);
        b1.cmd_valid = 1; b1.cmd_write = 1; b1.cmd_base = 3'd0; b1.cmd_len = 4'd8;
        b1.wr_valid = 1; b1.wr_data = 32'h100;
        #1 tests++;
        if (b1.cmd_ready !== 1'b1) begin fails++; $display("FAIL load_accept: got %b expected 1", b1.cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b1.cmd_valid = 0; b1.wr_data = 32'h100 + 32'(i);
            #1;
            obs = {b1.ce0, b1.we0, b1.wr_ready, b1.address0, b1.d0};
            exp = {3'b111, 3'(i), 32'h100 + 32'(i)};
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL load_word%0d: got %h expected %h", i, obs, exp); end
        end
        @(negedge clk); b1.wr_valid = 0; #1;
        tests++;
        if ({b1.done, b1.ce0, b1.cmd_ready} !== 3'b100) begin fails++; $display("FAIL load_done: got %b expected 100", {b1.done, b1.ce0, b1.cmd_ready}); end
        @(negedge clk); #1;
        tests++;
        if ({b1.done, b1.cmd_ready} !== 2'b01) begin fails++; $display("FAIL load_idle: got %b expected 01", {b1.done, b1.cmd_ready}); end
    endtask

    task automatic test_dump_wrap;
        logic [33:0] obs, exp;
        @(negedge clk);
        b1.cmd_valid = 1; b1.cmd_write = 0; b1.cmd_base = 3'd5; b1.cmd_len = 4'd6; b1.rd_ready = 1;
        @(negedge clk); b1.cmd_valid = 0; #1;
        tests++;
        if ({b1.ce0, b1.we0, b1.address0, b1.rd_valid} !== 6'b10_101_0) begin fails++; $display("FAIL dump_first_read: got %b expected 101010", {b1.ce0, b1.we0, b1.address0, b1.rd_valid}); end
        @(negedge clk); #1;
        tests++;
        if ({b1.ce0, b1.address0, b1.rd_valid} !== 5'b1_110_0) begin fails++; $display("FAIL dump_second_read: got %b expected 11100", {b1.ce0, b1.address0, b1.rd_valid}); end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); #1;
            obs = {b1.rd_valid, b1.rd_last, b1.rd_data};
            exp = {1'b1, j == 5, 32'h100 + 32'((5 + j) % 8)};
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL dump_word%0d: got %h expected %h", j, obs, exp); end
        end
        @(negedge clk); #1;
        tests++;
        if ({b1.done, b1.rd_valid, b1.ce0} !== 3'b100) begin fails++; $display("FAIL dump_done: got %b expected 100", {b1.done, b1.rd_valid, b1.ce0}); end
        @(negedge clk); b1.rd_ready = 0;
    endtask

    task automatic test_backpressure;
        int iss = 0, popc = 0;
        bit saw_done = 0;
        logic [32:0] obs, exp;
        b1.cmd_valid = 1; b1.cmd_write = 0; b1.cmd_base = 3'd0; b1.cmd_len = 4'd8; b1.rd_ready = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            b1.cmd_valid = 0;
            b1.rd_ready = ((i >= 4 && i < 9) || (i >= 15 && i < 20)) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (b1.done) begin saw_done = 1; break; end
            if (b1.ce0 && !b1.we0) iss++;
            if (b1.rd_valid) begin
                obs = {b1.rd_last, b1.rd_data};
                exp = {popc == 7, 32'h100 + 32'(popc)};
                tests++;
                if (obs !== exp) begin fails++; $display("FAIL bp_head%0d: got %h expected %h", popc, obs, exp); end
                if (b1.rd_ready) popc++;
            end
            tests++;
            if (iss - popc > 2) begin fails++; $display("FAIL bp_outstanding: got %0d expected <=2", iss - popc); end
        end
        tests++;
        if (!saw_done || popc != 8 || iss != 8) begin fails++; $display("FAIL bp_complete: got done=%0d pops=%0d reads=%0d expected 1/8/8", saw_done, popc, iss); end
        b1.rd_ready = 0;
    endtask

    task automatic test_len0;
        @(negedge clk);
        b1.cmd_valid = 1; b1.cmd_write = 1; b1.cmd_base = 3'd2; b1.cmd_len = 4'd0; b1.wr_valid = 1;
        #1 tests++;
        if (b1.ce0 !== 1'b0) begin fails++; $display("FAIL len0_accept_ce: got %b expected 0", b1.ce0); end
        @(negedge clk); b1.cmd_valid = 0; #1;
        tests++;
        if ({b1.done, b1.ce0, b1.we0, b1.wr_ready} !== 4'b1000) begin fails++; $display("FAIL len0_done: got %b expected 1000", {b1.done, b1.ce0, b1.we0, b1.wr_ready}); end
        @(negedge clk); #1;
        tests++;
        if ({b1.done, b1.cmd_ready, b1.ce0} !== 3'b010) begin fails++; $display("FAIL len0_idle: got %b expected 010", {b1.done, b1.cmd_ready, b1.ce0}); end
        b1.wr_valid = 0;
    endtask

    task automatic test_len9;
        int n = 0;
        bit saw_done = 0;
        logic [34:0] obs, exp;
        @(negedge clk);
        b1.cmd_valid = 1; b1.cmd_write = 1; b1.cmd_base = 3'd3; b1.cmd_len = 4'd9;
        b1.wr_valid = 1; b1.wr_data = 32'h200;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b1.cmd_valid = 0; b1.wr_data = 32'h200 + 32'(n);
            #1;
            if (b1.done) begin saw_done = 1; break; end
            if (b1.we0) begin
                obs = {b1.address0, b1.d0};
                exp = {3'((3 + n) % 8), 32'h200 + 32'(n)};
                tests++;
                if (obs !== exp) begin fails++; $display("FAIL len9_word%0d: got %h expected %h", n, obs, exp); end
                n++;
            end
        end
        tests++;
        if (!saw_done || n != 8) begin fails++; $display("FAIL len9_clamp: got done=%0d words=%0d expected 1/8", saw_done, n); end
        b1.wr_valid = 0;
    endtask

    task automatic test_range6;
        int n = 0;
        bit saw_done = 0;
        logic [2:0] exp_a [4] = '{3'd4, 3'd5, 3'd0, 3'd1};
        @(negedge clk);
        b2.cmd_valid = 1; b2.cmd_write = 1; b2.cmd_base = 3'd4; b2.cmd_len = 4'd4;
        b2.wr_valid = 1; b2.wr_data = 32'h400;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b2.cmd_valid = 0; b2.wr_data = 32'h400 + 32'(n);
            #1;
            if (b2.done) begin saw_done = 1; break; end
            if (b2.we0) begin
                tests++;
                if (n > 3 || b2.address0 !== exp_a[n & 3]) begin fails++; $display("FAIL range6_addr%0d: got %0d expected %0d", n, b2.address0, exp_a[n & 3]); end
                n++;
            end
        end
        tests++;
        if (!saw_done || n != 4) begin fails++; $display("FAIL range6_count: got done=%0d words=%0d expected 1/4", saw_done, n); end
        b2.wr_valid = 0;
    endtask

    task automatic test_reset_mid;
        logic [9:0] obs;
        logic [31:0] exp_d [3] = '{32'h205, 32'h206, 32'h207};
        @(negedge clk);
        b1.cmd_valid = 1; b1.cmd_write = 0; b1.cmd_base = 3'd0; b1.cmd_len = 4'd8; b1.rd_ready = 1;
        @(negedge clk); b1.cmd_valid = 0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #1;
            tests++;
            if ({b1.rd_valid, b1.rd_data} !== {1'b1, exp_d[j]}) begin fails++; $display("FAIL abort_word%0d: got %h expected %h", j, {b1.rd_valid, b1.rd_data}, {1'b1, exp_d[j]}); end
        end
        @(negedge clk);
        reset = 0;
        #1;
        obs = {b1.cmd_ready, b1.wr_ready, b1.rd_valid, b1.rd_last, b1.done, b1.ce0, b1.we0, b1.address0};
        tests++;
        if (obs !== 10'b1000000000) begin fails++; $display("FAIL abort_outputs: got %b expected %b", obs, 10'b1000000000); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            tests++;
            if ({b1.ce0, b1.we0, b1.done, b1.rd_valid} !== 4'b0000) begin fails++; $display("FAIL abort_quiet%0d: got %b expected 0000", k, {b1.ce0, b1.we0, b1.done, b1.rd_valid}); end
        end
        @(negedge clk); reset = 1; b1.rd_ready = 0;
        @(negedge clk);
        b1.cmd_valid = 1; b1.cmd_write = 1; b1.cmd_base = 3'd0; b1.cmd_len = 4'd2;
        b1.wr_valid = 1; b1.wr_data = 32'h300;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            b1.cmd_valid = 0; b1.wr_data = 32'h300 + 32'(i);
            #1 tests++;
            if ({b1.we0, b1.address0} !== {1'b1, 3'(i)}) begin fails++; $display("FAIL post_reset_write%0d: got %b expected %b", i, {b1.we0, b1.address0}, {1'b1, 3'(i)}); end
        end
        @(negedge clk); b1.wr_valid = 0; #1;
        tests++;
        if (b1.done !== 1'b1) begin fails++; $display("FAIL post_reset_done: got %b expected 1", b1.done); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_dump_wrap();
        test_backpressure();
        test_len0();
        test_len9();
        test_range6();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mpc_vector_ram_master.md
# mpc_vector_ram_master

Command-driven port master for the single-port, read-first vector RAMs used by the MPC controller datapath, such as constraint and temporary vectors. It drives the RAM's `address0/ce0/we0/d0/q0` port on one side. On the other side it exposes valid/ready streams: burst-loading a vector into RAM, or burst-dumping a vector out of RAM. It absorbs the RAM's 1-cycle read latency and applies backpressure, so producers and consumers never see RAM timing.

## Interface
- `DataWidth`, 32, word width; matches the RAM.
- `AddressWidth`, 3, RAM address width.
- `AddressRange`, 8, number of RAM words; must be ≤ 2^AddressWidth and need not be a power of 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = load (stream→RAM), 0 = dump (RAM→stream).
- `cmd_base` in AddressWidth: start address, < AddressRange.
- `cmd_len` in AddressWidth+1: word count; 0 is legal.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in DataWidth: load stream.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out DataWidth, `rd_last` out 1: dump stream.
- `done` out 1: 1-cycle pulse when a command completes.
- `address0` out AddressWidth, `ce0` out 1, `we0` out 1, `d0` out DataWidth: RAM port outputs.
- `q0` in DataWidth: RAM read data, valid the cycle after `ce0 & ~we0`.

## Operation
- States: IDLE, WRITE, READ, FIN.
- IDLE: `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch base, length and direction. Effective length = min(cmd_len, AddressRange).
  - Effective length 0 → FIN, with no RAM access.
  - Otherwise, `cmd_write`=1 → WRITE and `cmd_write`=0 → READ.
- WRITE: `wr_ready`=1. `ce0 = we0 = wr_valid`, `d0 = wr_data`, `address0` = current pointer.
  - Each handshake writes one word and advances the pointer.
  - After the final word → FIN.
- READ: issue read (`ce0`=1, `we0`=0) when words remain to issue and `occ + inflight − pop < 2`.
  - `occ` = output buffer occupancy (0..2), `inflight` = read issued last cycle, `pop` = `rd_valid & rd_ready`.
  - `q0` is captured into the 2-entry buffer the cycle after issue.
  - `rd_valid` = buffer non-empty; `rd_data` = buffer head; `rd_last` = head is the final word of the command.
  - When the final word pops → FIN.
- FIN: `done`=1 for exactly one cycle → IDLE.
- Pointer: starts at `cmd_base` and increments by 1. AddressRange−1 wraps to 0 (not 2^AddressWidth).
- `ce0`, `we0` and `wr_ready` are combinational from state and handshakes.
- No `ce0` outside WRITE/READ, and never a write in READ.
- Commands are never queued; `cmd_valid` outside IDLE is ignored.
- Reset values: state IDLE, `cmd_ready`=1, all other outputs 0, buffer empty, pointer 0.
- Reset mid-command: abort immediately and discard buffered data. No further `ce0`/`we0` after `reset` falls. No `done` is issued for the aborted command.

## Timing
- Load: command accepted at cycle T; `wr_ready` high from T+1.
  - With `wr_valid` held high, words go to RAM at T+1..T+L.
  - `done` at T+L+1; `cmd_ready` high at T+L+2.
- Dump: command accepted at T; first read at T+1; `q0` valid at T+2; buffered, `rd_valid` at T+3.
- With `rd_ready` held high, throughput is 1 word/cycle. The last word is at T+L+2, `done` at T+L+3.
- `rd_ready` low: at most 2 reads are outstanding (buffered plus in flight). The buffer never overflows and no word is lost or duplicated.
- `rd_data`/`rd_last` are stable while `rd_valid & ~rd_ready`.

## Structure
- Package `mpc_vector_ram_pkg`: state enum (IDLE/WRITE/READ/FIN), command struct (write, base, len), buffer depth constant = 2.
- Sub-module `mpc_vector_ram_rdbuf`: 2-entry synchronous FIFO with data plus last flag, push/pop, occupancy output, async active-low reset.
- Top level holds the FSM, pointer/wrap logic, remaining-issue and remaining-pop counters, and the credit check.

## Test plan
- Load base=0, len=8, data 0x100..0x107, `wr_valid` always high → 8 consecutive `we0` cycles at addresses 0..7; `done` 9 cycles after accept.
- Dump base=5, len=6, `rd_ready` always high, RAM[i]=0x100+i → `rd_data` 0x105,0x106,0x107,0x100,0x101,0x102 (wrap at 7→0); `rd_last` on 0x102; 1 word/cycle.
- Dump len=8 with `rd_ready` toggled randomly, including 5-cycle stalls → exact in-order sequence, never more than 2 outstanding, `rd_data` held during stalls.
- `AddressRange`=6, load base=4, len=4 → writes to addresses 4,5,0,1.
- Boundary commands:
  - len=0 → `done` the cycle after accept, no `ce0`.
  - len=9 with `AddressRange`=8 → clamped to 8 words.
- Reset asserted mid-dump after 3 words → outputs to reset values in the same cycle (asynchronously). After release, a new load completes normally.
